// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - VGA mode constants shared with video_controller, lock-state type
package vga_timing_pkg;

  localparam int unsigned H_PIXELS        = 800;
  localparam int unsigned V_LINES         = 521;
  localparam int unsigned H_PULSE         = 96;
  localparam int unsigned H_BP            = 144;
  localparam int unsigned H_FP            = 784;
  localparam int unsigned V_BP            = 31;
  localparam int unsigned V_FP            = 511;
  localparam int unsigned LOCK_FRAMES_DEF = 2;

  localparam int unsigned      CNT_W   = 10;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    TRACK  = 2'd1,
    LOCKED = 2'd2
  } lock_state_e;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/vga_edge_detect.sv
// rtl/vga_edge_detect.sv - two-stage sync register with fall/rise pulses
module vga_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic q,
  output logic fall,
  output logic rise
);

  logic s1_q, s1_d;
  logic s2_q, s2_d;

  always_comb begin
    s1_d = din;
    s2_d = s1_q;
  end

  // Syncs idle high, so reset to high to avoid reporting a phantom edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= 1'b1;
      s2_q <= 1'b1;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  assign q    = s1_q;
  assign fall = ~s1_q & s2_q;
  assign rise = s1_q & ~s2_q;

endmodule

// File: rtl/vga_timing_rx.sv
// rtl/vga_timing_rx.sv - VGA timing receiver: recovers pixel coordinates, measures timing, locks
module vga_timing_rx
  import vga_timing_pkg::*;
#(
  parameter int unsigned HPIXELS     = H_PIXELS,
  parameter int unsigned VLINES      = V_LINES,
  parameter int unsigned HPULSE      = H_PULSE,
  parameter int unsigned HBP         = H_BP,
  parameter int unsigned HFP         = H_FP,
  parameter int unsigned VBP         = V_BP,
  parameter int unsigned VFP         = V_FP,
  parameter int unsigned LOCK_FRAMES = LOCK_FRAMES_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       h_sync,
  input  logic       v_sync,
  input  logic [5:0] red_in,
  input  logic [5:0] green_in,
  input  logic [5:0] blue_in,
  output logic [9:0] px_h,
  output logic [9:0] px_v,
  output logic       px_valid,
  output logic [5:0] red,
  output logic [5:0] green,
  output logic [5:0] blue,
  output logic       frame_start,
  output logic       locked,
  output logic [9:0] line_len,
  output logic [9:0] hs_width,
  output logic [9:0] frame_lines
);

  localparam logic [CNT_W-1:0] HPIX_C  = CNT_W'(HPIXELS);
  localparam logic [CNT_W-1:0] VLIN_C  = CNT_W'(VLINES);
  localparam logic [CNT_W-1:0] HPUL_C  = CNT_W'(HPULSE);
  localparam logic [CNT_W-1:0] HBP_C   = CNT_W'(HBP);
  localparam logic [CNT_W-1:0] HFP_C   = CNT_W'(HFP);
  localparam logic [CNT_W-1:0] VBP_C   = CNT_W'(VBP);
  localparam logic [CNT_W-1:0] VFP_C   = CNT_W'(VFP);
  localparam logic [7:0]       LOCK_C  = 8'(LOCK_FRAMES);

  logic hs_q, hfall, hs_rise;
  logic vs_q, vs_fall, vs_rise;
  logic vs_unused;

  vga_edge_detect u_hs_edge (
    .clk  (clk),
    .rst  (rst),
    .din  (h_sync),
    .q    (hs_q),
    .fall (hfall),
    .rise (hs_rise)
  );

  vga_edge_detect u_vs_edge (
    .clk  (clk),
    .rst  (rst),
    .din  (v_sync),
    .q    (vs_q),
    .fall (vs_fall),
    .rise (vs_rise)
  );

  assign vs_unused = vs_fall ^ vs_rise;

  logic [5:0]       red_in_q, red_in_d, green_in_q, green_in_d, blue_in_q, blue_in_d;
  logic [CNT_W-1:0] hc_q, hc_d, vpos_q, vpos_d, lo_cnt_q, lo_cnt_d;
  logic [CNT_W-1:0] line_len_q, line_len_d, hs_width_q, hs_width_d;
  logic [CNT_W-1:0] frame_lines_q, frame_lines_d;
  logic [CNT_W-1:0] px_h_q, px_h_d, px_v_q, px_v_d;
  logic [5:0]       red_q, red_d, green_q, green_d, blue_q, blue_d;
  logic             vs_line_q, vs_line_d, frame_ok_q, frame_ok_d;
  logic             px_valid_q, px_valid_d, frame_start_q, frame_start_d;
  logic [7:0]       good_cnt_q, good_cnt_d, good_inc;
  lock_state_e      state_q, state_d;

  logic [CNT_W-1:0] hpos;
  logic             fs_hit, line_bad, frame_good, in_h, in_v;

  always_comb begin
    red_in_d   = red_in;
    green_in_d = green_in;
    blue_in_d  = blue_in;

    hc_d = hfall ? CNT_W'(1) : sat_inc(hc_q);
    hpos = hfall ? '0 : hc_q;

    // A frame begins on the line whose sampled vsync is low after a high one.
    vs_line_d = hfall ? vs_q : vs_line_q;
    fs_hit    = hfall & ~vs_q & vs_line_q;
    if (fs_hit)     vpos_d = '0;
    else if (hfall) vpos_d = sat_inc(vpos_q);
    else            vpos_d = vpos_q;

    lo_cnt_d      = hs_q ? '0 : sat_inc(lo_cnt_q);
    hs_width_d    = hs_rise ? lo_cnt_q : hs_width_q;
    line_len_d    = hfall ? hc_q : line_len_q;
    frame_lines_d = fs_hit ? sat_inc(vpos_q) : frame_lines_q;

    // The line closed by this hfall is judged on its own period and its own hsync pulse.
    line_bad   = hfall & ~((hc_q == HPIX_C) & (hs_width_q == HPUL_C));
    frame_good = frame_ok_q & ~line_bad & (sat_inc(vpos_q) == VLIN_C);
    if (fs_hit)        frame_ok_d = 1'b1;
    else if (line_bad) frame_ok_d = 1'b0;
    else               frame_ok_d = frame_ok_q;
  end

  always_comb begin
    state_d    = state_q;
    good_cnt_d = good_cnt_q;
    good_inc   = good_cnt_q + 8'd1;
    case (state_q)
      SEARCH: begin
        if (fs_hit) begin
          state_d    = TRACK;
          good_cnt_d = '0;
        end
      end
      TRACK: begin
        if (fs_hit) begin
          if (!frame_good) begin
            good_cnt_d = '0;
          end else if (good_inc >= LOCK_C) begin
            state_d    = LOCKED;
            good_cnt_d = good_inc;
          end else begin
            good_cnt_d = good_inc;
          end
        end
      end
      LOCKED: begin
        if (line_bad || (hc_q == CNT_MAX)) begin
          state_d    = SEARCH;
          good_cnt_d = '0;
        end
      end
      default: begin
        state_d    = SEARCH;
        good_cnt_d = '0;
      end
    endcase
  end

  // Qualify with the next lock state so px_valid and locked change on the same cycle.
  always_comb begin
    in_h          = (hpos >= HBP_C) && (hpos < HFP_C);
    in_v          = (vpos_d >= VBP_C) && (vpos_d < VFP_C);
    px_valid_d    = (state_d == LOCKED) && in_h && in_v;
    px_h_d        = px_valid_d ? hpos - HBP_C : '0;
    px_v_d        = px_valid_d ? vpos_d - VBP_C : '0;
    red_d         = px_valid_d ? red_in_q : '0;
    green_d       = px_valid_d ? green_in_q : '0;
    blue_d        = px_valid_d ? blue_in_q : '0;
    frame_start_d = (vpos_d == '0) && (hpos == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      red_in_q      <= '0;
      green_in_q    <= '0;
      blue_in_q     <= '0;
      hc_q          <= '0;
      vpos_q        <= CNT_MAX;
      vs_line_q     <= 1'b1;
      lo_cnt_q      <= '0;
      line_len_q    <= '0;
      hs_width_q    <= '0;
      frame_lines_q <= '0;
      frame_ok_q    <= 1'b0;
      state_q       <= SEARCH;
      good_cnt_q    <= '0;
      px_valid_q    <= 1'b0;
      px_h_q        <= '0;
      px_v_q        <= '0;
      red_q         <= '0;
      green_q       <= '0;
      blue_q        <= '0;
      frame_start_q <= 1'b0;
    end else begin
      red_in_q      <= red_in_d;
      green_in_q    <= green_in_d;
      blue_in_q     <= blue_in_d;
      hc_q          <= hc_d;
      vpos_q        <= vpos_d;
      vs_line_q     <= vs_line_d;
      lo_cnt_q      <= lo_cnt_d;
      line_len_q    <= line_len_d;
      hs_width_q    <= hs_width_d;
      frame_lines_q <= frame_lines_d;
      frame_ok_q    <= frame_ok_d;
      state_q       <= state_d;
      good_cnt_q    <= good_cnt_d;
      px_valid_q    <= px_valid_d;
      px_h_q        <= px_h_d;
      px_v_q        <= px_v_d;
      red_q         <= red_d;
      green_q       <= green_d;
      blue_q        <= blue_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign px_h        = px_h_q;
  assign px_v        = px_v_q;
  assign px_valid    = px_valid_q;
  assign red         = red_q;
  assign green       = green_q;
  assign blue        = blue_q;
  assign frame_start = frame_start_q;
  assign locked      = (state_q == LOCKED);
  assign line_len    = line_len_q;
  assign hs_width    = hs_width_q;
  assign frame_lines = frame_lines_q;

endmodule
